// File: rtl/fetch_ctrl.sv
// Command fetch controller: walks a small command memory from address 0, follows
// jump words internally and hands plain commands to a decoder one at a time.
module fetch_ctrl #(
  parameter int ADR_W    = 4,
  parameter int PROG_LEN = 5,
  parameter bit WRAP     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             mem_req,
  output logic [ADR_W-1:0] mem_adr,
  input  logic [31:0]      mem_cmd,
  input  logic             mem_vld,
  output logic [31:0]      instr,
  output logic             instr_vld,
  input  logic             instr_rdy,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       fetch_cnt
);

  // Handshake: a command transfers on a rising edge where instr_vld and instr_rdy
  // are both 1; while instr_vld=1 and instr_rdy=0, instr is held unchanged. On the
  // memory side, a one-cycle mem_req is answered by mem_vld with mem_cmd, any
  // number of cycles later; mem_vld outside WAIT is ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(PROG_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ADR_W-1:0] pc;
  logic [ADR_W-1:0] pc_nxt;
  logic [31:0]      instr_nxt;
  logic [7:0]       cnt_nxt;
  logic             err_nxt;
  logic             done_nxt;

  logic             is_jump;
  logic [ADR_W-1:0] jump_tgt;
  logic             tgt_ok;
  logic             before_last;

  assign is_jump     = (mem_cmd[31:26] == 6'b111111);
  assign jump_tgt    = mem_cmd[ADR_W-1:0];
  assign tgt_ok      = (32'(jump_tgt) < 32'(PROG_LEN));
  assign before_last = (pc < LAST_ADR);
  assign mem_adr     = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= '0;
      fetch_cnt <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr     <= instr_nxt;
      fetch_cnt <= cnt_nxt;
      err       <= err_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    cnt_nxt   = fetch_cnt;
    err_nxt   = err;
    done_nxt  = 1'b0;
    mem_req   = 1'b0;
    instr_vld = 1'b0;
    busy      = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          pc_nxt    = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_vld) begin
          // Jump words are consumed here and never reach the decoder.
          if (is_jump) begin
            if (tgt_ok) begin
              pc_nxt    = jump_tgt;
              state_nxt = REQ;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            instr_nxt = mem_cmd;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        instr_vld = 1'b1;
        if (instr_rdy) begin
          cnt_nxt = (fetch_cnt == 8'hff) ? fetch_cnt : fetch_cnt + 8'd1;
          if (before_last) begin
            pc_nxt    = pc + ADR_W'(1);
            state_nxt = REQ;
          end else if (WRAP) begin
            pc_nxt    = '0;
            state_nxt = REQ;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // stop wins over start and over an accepted handshake; progress state is kept.
    if (stop) begin
      state_nxt = IDLE;
      pc_nxt    = pc;
      instr_nxt = instr;
      cnt_nxt   = fetch_cnt;
      err_nxt   = err;
      done_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a WRAP=1 and a WRAP=0 instance share control inputs, each
// with its own single-cycle memory responder, checked against a program-walk model.
module tb_fetch_ctrl;
  localparam int ADR_W    = 4;
  localparam int PROG_LEN = 5;
  localparam logic [5:0] JUMP_OP = 6'h3f;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, stop = 1'b0, instr_rdy = 1'b0;

  logic             mem_req0, mem_req1;
  logic [ADR_W-1:0] mem_adr0, mem_adr1;
  logic [31:0]      mem_cmd0 = '0, mem_cmd1 = '0;
  logic             mem_vld0 = 1'b0, mem_vld1 = 1'b0;
  logic [31:0]      instr0, instr1;
  logic             instr_vld0, instr_vld1;
  logic             busy0, busy1, done0, done1, err0, err1;
  logic [7:0]       fetch_cnt0, fetch_cnt1;

  fetch_ctrl #(.ADR_W(ADR_W), .PROG_LEN(PROG_LEN), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mem_req(mem_req0), .mem_adr(mem_adr0), .mem_cmd(mem_cmd0), .mem_vld(mem_vld0),
    .instr(instr0), .instr_vld(instr_vld0), .instr_rdy(instr_rdy),
    .busy(busy0), .done(done0), .err(err0), .fetch_cnt(fetch_cnt0)
  );

  fetch_ctrl #(.ADR_W(ADR_W), .PROG_LEN(PROG_LEN), .WRAP(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mem_req(mem_req1), .mem_adr(mem_adr1), .mem_cmd(mem_cmd1), .mem_vld(mem_vld1),
    .instr(instr1), .instr_vld(instr_vld1), .instr_rdy(instr_rdy),
    .busy(busy1), .done(done1), .err(err1), .fetch_cnt(fetch_cnt1)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0]      mem [0:15];
  logic [31:0]      exp_q[$];
  logic [31:0]      exp_q_nw[$];
  bit               m_term [2];
  bit               m_err [2];
  int               m_k [2];
  int               dcnt [2];
  int               dones [2];
  bit               auto_mem = 1'b1;
  logic             pend_req [2];
  logic [ADR_W-1:0] pend_adr [2];
  logic [31:0]      saved_instr;
  logic [7:0]       saved_cnt;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected delivery stream from walking the program: jumps redirect, plain words
  // are delivered in order, the end of the program wraps or terminates.
  task automatic model(input int d);
    int pc;
    logic [31:0] w;
    pc = 0;
    m_term[d] = 1'b0;
    m_err[d] = 1'b0;
    m_k[d] = 0;
    if (d == 0) exp_q.delete(); else exp_q_nw.delete();
    for (int steps = 0; steps < 400 && !m_term[d]; steps++) begin
      w = mem[pc];
      if (w[31:26] == JUMP_OP) begin
        if (int'(w[3:0]) >= PROG_LEN) begin
          m_err[d] = 1'b1;
          m_term[d] = 1'b1;
        end else begin
          pc = int'(w[3:0]);
        end
      end else begin
        if (d == 0) exp_q.push_back(w); else exp_q_nw.push_back(w);
        m_k[d]++;
        if (pc < PROG_LEN - 1) pc++;
        else if (d == 0) pc = 0;
        else m_term[d] = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    if (!rst && !stop) begin
      if (instr_vld0 && instr_rdy) begin
        chk("dut_q_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("dut_instr", instr0, exp_q.pop_front());
        dcnt[0]++;
      end
      if (instr_vld1 && instr_rdy) begin
        chk("nw_q_avail", 32'(exp_q_nw.size() != 0), 1);
        if (exp_q_nw.size() != 0) chk("nw_instr", instr1, exp_q_nw.pop_front());
        dcnt[1]++;
      end
    end
    if (done0) dones[0]++;
    if (done1) begin
      dones[1]++;
      chk("nw_done_at_last", dcnt[1], m_k[1]);
    end
  endtask

  // driver: one clock cycle, with a single-cycle memory answering last cycle's request
  task automatic tick();
    monitor();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_vld0 = pend_req[0];
      mem_cmd0 = pend_req[0] ? mem[pend_adr[0]] : $urandom();
      mem_vld1 = pend_req[1];
      mem_cmd1 = pend_req[1] ? mem[pend_adr[1]] : $urandom();
    end
    pend_req[0] = mem_req0;
    pend_adr[0] = mem_adr0;
    pend_req[1] = mem_req1;
    pend_adr[1] = mem_adr1;
  endtask

  task automatic begin_run();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    tick();
    rst = 1'b0;
    dcnt = '{0, 0};
    dones = '{0, 0};
    pend_req = '{1'b0, 1'b0};
    model(0);
    model(1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 20 && !instr_vld0; i++) tick();
    chk("hold_reached", 32'(instr_vld0), 1);
  endtask

  task automatic finish_check(input int d);
    logic b, e;
    logic [7:0] fc;
    int qs;
    if (d == 0) begin b = busy0; e = err0; fc = fetch_cnt0; qs = exp_q.size(); end
    else begin b = busy1; e = err1; fc = fetch_cnt1; qs = exp_q_nw.size(); end
    if (m_term[d]) begin
      chk($sformatf("d%0d_end_busy", d), 32'(b), 0);
      chk($sformatf("d%0d_end_err", d), 32'(e), 32'(m_err[d]));
      chk($sformatf("d%0d_end_cnt", d), 32'(fc), m_k[d]);
      chk($sformatf("d%0d_end_qleft", d), qs, 0);
      chk($sformatf("d%0d_end_dones", d), dones[d], (d == 1 && !m_err[d]) ? 1 : 0);
    end else begin
      chk($sformatf("d%0d_run_busy", d), 32'(b), 1);
      chk($sformatf("d%0d_run_err", d), 32'(e), 0);
      chk($sformatf("d%0d_run_cnt", d), 32'(fc), (dcnt[d] > 255) ? 255 : dcnt[d]);
      chk($sformatf("d%0d_run_dones", d), dones[d], 0);
    end
  endtask

  task automatic plain_mem();
    for (int i = 0; i < 16; i++) mem[i] = {2'b01, 30'($urandom())};
  endtask

  task automatic rand_mem();
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) == 0) w = {JUMP_OP, 22'($urandom()), 4'($urandom_range(0, 7))};
      else if (w[31:26] == JUMP_OP) w[31] = 1'b0;
      mem[i] = w;
    end
  endtask

  initial begin
    // Reset values
    begin_run();
    chk("rst_mem_req", 32'(mem_req0), 0);
    chk("rst_mem_adr", 32'(mem_adr0), 0);
    chk("rst_instr", instr0, 0);
    chk("rst_instr_vld", 32'(instr_vld0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_fetch_cnt", 32'(fetch_cnt0), 0);

    // Program {c0,c1,c2,c3,jump->1}: first-fetch latency, then looping stream
    plain_mem();
    mem[4] = {JUMP_OP, 26'd1};
    begin_run();
    instr_rdy = 1'b1;
    do_start();
    chk("lat_c1_mem_req", 32'(mem_req0), 1);
    chk("lat_c1_mem_adr", 32'(mem_adr0), 0);
    chk("lat_c1_busy", 32'(busy0), 1);
    tick();
    chk("lat_c2_mem_req", 32'(mem_req0), 0);
    chk("lat_c2_instr_vld", 32'(instr_vld0), 0);
    tick();
    chk("lat_c3_instr_vld", 32'(instr_vld0), 1);
    chk("lat_c3_instr", instr0, mem[0]);
    for (int i = 0; i < 40; i++) tick();
    chk("loop_deliveries", 32'(dcnt[0] >= 10), 1);
    chk("loop_err", 32'(err0), 0);

    // Decoder stall in HOLD
    instr_rdy = 1'b0;
    wait_hold();
    saved_instr = instr0;
    saved_cnt = fetch_cnt0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_vld", 32'(instr_vld0), 1);
      chk("stall_instr", instr0, saved_instr);
      chk("stall_mem_req", 32'(mem_req0), 0);
      chk("stall_cnt", 32'(fetch_cnt0), 32'(saved_cnt));
      tick();
    end
    instr_rdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    finish_check(0);
    finish_check(1);

    // Out-of-range jump at address 2, then a new start clears err
    plain_mem();
    mem[2] = {JUMP_OP, 26'd7};
    begin_run();
    instr_rdy = 1'b1;
    do_start();
    for (int i = 0; i < 30; i++) tick();
    chk("badjump_err", 32'(err0), 1);
    chk("badjump_cnt", 32'(fetch_cnt0), 2);
    finish_check(0);
    finish_check(1);
    do_start();
    chk("restart_err_clr", 32'(err0), 0);
    chk("restart_cnt_clr", 32'(fetch_cnt0), 0);
    chk("restart_busy", 32'(busy0), 1);

    // WRAP=0, five plain commands
    plain_mem();
    begin_run();
    instr_rdy = 1'b1;
    do_start();
    for (int i = 0; i < 30; i++) tick();
    chk("nw_fetch5", 32'(fetch_cnt1), 5);
    chk("nw_dones", dones[1], 1);
    finish_check(1);

    // stop in WAIT, late mem_vld ignored
    plain_mem();
    begin_run();
    auto_mem = 1'b0;
    mem_vld0 = 1'b0;
    mem_vld1 = 1'b0;
    do_start();
    tick();
    chk("stopw_in_wait", 32'(busy0 && !mem_req0 && !instr_vld0), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stopw_busy", 32'(busy0), 0);
    chk("stopw_vld", 32'(instr_vld0), 0);
    chk("stopw_mem_req", 32'(mem_req0), 0);
    mem_vld0 = 1'b1;
    mem_cmd0 = {2'b01, 30'($urandom())};
    mem_vld1 = 1'b1;
    mem_cmd1 = mem_cmd0;
    tick();
    mem_vld0 = 1'b0;
    mem_vld1 = 1'b0;
    chk("late_vld_busy", 32'(busy0), 0);
    chk("late_vld_instr_vld", 32'(instr_vld0), 0);
    chk("late_vld_instr", instr0, 0);
    tick();
    chk("late_vld_idle", 32'(busy0), 0);
    auto_mem = 1'b1;

    // stop in HOLD overrides instr_rdy; stop overrides start in IDLE
    instr_rdy = 1'b0;
    do_start();
    wait_hold();
    instr_rdy = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stoph_busy", 32'(busy0), 0);
    chk("stoph_vld", 32'(instr_vld0), 0);
    chk("stoph_cnt", 32'(fetch_cnt0), 0);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    chk("stop_over_start", 32'(busy0), 0);

    // rst in HOLD after a few deliveries
    plain_mem();
    begin_run();
    instr_rdy = 1'b1;
    do_start();
    for (int i = 0; i < 7; i++) tick();
    instr_rdy = 1'b0;
    wait_hold();
    instr_rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsth_mem_req", 32'(mem_req0), 0);
    chk("rsth_mem_adr", 32'(mem_adr0), 0);
    chk("rsth_instr", instr0, 0);
    chk("rsth_instr_vld", 32'(instr_vld0), 0);
    chk("rsth_busy", 32'(busy0), 0);
    chk("rsth_done", 32'(done0), 0);
    chk("rsth_err", 32'(err0), 0);
    chk("rsth_cnt", 32'(fetch_cnt0), 0);
    auto_mem = 1'b0;
    mem_vld0 = 1'b1;
    mem_cmd0 = {2'b01, 30'($urandom())};
    tick();
    mem_vld0 = 1'b0;
    chk("rsth_late_vld", 32'(instr_vld0), 0);
    chk("rsth_late_busy", 32'(busy0), 0);
    auto_mem = 1'b1;

    // Randomized programs with random decoder back-pressure
    for (int r = 0; r < 8; r++) begin
      rand_mem();
      begin_run();
      do_start();
      for (int i = 0; i < 150; i++) begin
        instr_rdy = ($urandom_range(0, 2) != 0);
        tick();
      end
      finish_check(0);
      finish_check(1);
    end

    // fetch_cnt saturation
    plain_mem();
    begin_run();
    instr_rdy = 1'b1;
    do_start();
    for (int i = 0; i < 820; i++) tick();
    chk("sat_deliveries", 32'(dcnt[0] > 255), 1);
    chk("sat_cnt", 32'(fetch_cnt0), 255);
    finish_check(0);
    finish_check(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The parameters SHALL be, one per line:
  ADR_W, 4, command-memory address width
  PROG_LEN, 5, number of valid command addresses (0..PROG_LEN-1)
  WRAP, 1, 1 = restart at address 0 after last address; 0 = stop
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; ports, one per line:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  synchronous active-high reset
  start  in  1  begin fetching at address 0 (sampled in IDLE only)
  stop  in  1  abort fetching, return to IDLE
  mem_req  out  1  read request to command memory (drives in_cmd_mem)
  mem_adr  out  ADR_W  read address (drives adr_cmd)
  mem_cmd  in  32  command word from memory (cmd)
  mem_vld  in  1  memory output valid (out_cmd_mem)
  instr  out  32  command presented to decoder
  instr_vld  out  1  instr valid
  instr_rdy  in  1  decoder accepts instr
  busy  out  1  state is not IDLE
  done  out  1  one-cycle pulse: program end reached with WRAP=0
  err  out  1  sticky: jump target >= PROG_LEN
  fetch_cnt  out  8  delivered-command count, saturating at 255

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, HOLD.
REQ-004 IDLE: mem_req=0, instr_vld=0; start=1 and stop=0 -> pc<=0, fetch_cnt<=0, next REQ.
REQ-005 REQ: mem_req=1, mem_adr=pc for exactly one cycle; next WAIT.
REQ-006 WAIT: mem_req=0; stay until mem_vld=1; at that edge capture mem_cmd.
REQ-007 Jump decode: captured mem_cmd[31:26]==6'b111111 is a jump; target = mem_cmd[ADR_W-1:0]; the jump word SHALL never be presented on instr.
REQ-008 Jump with target < PROG_LEN: pc<=target, next REQ; target >= PROG_LEN: err<=1, next IDLE.
REQ-009 Non-jump: instr<=mem_cmd, next HOLD; instr_vld=1 throughout HOLD, instr stable until accepted.
REQ-010 HOLD, instr_rdy=1: fetch_cnt increments (saturating); if pc < PROG_LEN-1 then pc<=pc+1, next REQ.
REQ-011 HOLD, instr_rdy=1 at pc==PROG_LEN-1: WRAP=1 -> pc<=0, next REQ; WRAP=0 -> done pulses 1 cycle, next IDLE.
REQ-012 HOLD, instr_rdy=0: no state change, indefinitely.
REQ-013 stop=1 in any state SHALL force IDLE at next edge; instr_vld, mem_req low the following cycle; pc, fetch_cnt, err retained; stop overrides start and instr_rdy in the same cycle.
REQ-014 A mem_vld arriving after stop SHALL be ignored.
REQ-015 Latency: start sampled at cycle 0 -> mem_req=1 cycle 1 -> mem_vld cycle 2 (single-cycle memory) -> instr_vld=1 cycle 3; back-to-back non-jump throughput is one command per 3 cycles.
REQ-016 busy=1 in REQ, WAIT, HOLD; 0 in IDLE.
REQ-017 err SHALL clear only on rst or on a new start accepted in IDLE.

Reset
REQ-018 rst=1 SHALL force at next edge: state IDLE, pc=0, mem_req=0, mem_adr=0, instr=0, instr_vld=0, busy=0, done=0, err=0, fetch_cnt=0.
REQ-019 rst SHALL take priority over start, stop, and any handshake; rst mid-HOLD drops instr_vld with no fetch_cnt increment.

Verification
REQ-020 Memory {cmd0,cmd1,cmd2,cmd3,jump->1}, WRAP=1, instr_rdy=1: start -> instr sequence cmd0,cmd1,cmd2,cmd3,cmd1,cmd2,cmd3,...; jump word never on instr; err=0.
REQ-021 Same memory, first instr_vld: start at cycle 0 -> mem_req cycle 1 with mem_adr=0, instr_vld=1 cycle 3, instr=cmd0.
REQ-022 instr_rdy=0 for 10 cycles in HOLD -> instr_vld held, instr unchanged, mem_req=0 throughout, fetch_cnt unchanged.
REQ-023 Memory word 2 = jump->7, PROG_LEN=5 -> cmd0,cmd1 delivered, then err=1, busy=0, fetch_cnt=2.
REQ-024 WRAP=0, no jump, 5 plain commands -> 5 deliveries, done pulses once at 5th acceptance, state IDLE, fetch_cnt=5.
REQ-025 stop asserted in WAIT (and rst asserted in HOLD on a separate run) -> IDLE next cycle, instr_vld=0, late mem_vld ignored; rst run shows all REQ-018 values.
